rv_imm_arb: RTL

//  Shares one immediate-extraction datapath between NUM_REQ requesters (decode, branch-target precompute, ...).

---
 rtl/rv_imm_pkg.sv | 26 ++
 rtl/rv_imm_fmt.sv | 50 +++++
 rtl/rv_imm_arb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rv_imm_pkg.sv
// Shared opcode constants, immediate format encodings and output-stage states
// for the rv_imm_arb immediate-extraction arbiter.
package rv_imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] IMM_FMT_NONE = 3'd0;
  localparam logic [2:0] IMM_FMT_I    = 3'd1;
  localparam logic [2:0] IMM_FMT_S    = 3'd2;
  localparam logic [2:0] IMM_FMT_B    = 3'd3;
  localparam logic [2:0] IMM_FMT_U    = 3'd4;
  localparam logic [2:0] IMM_FMT_J    = 3'd5;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/rv_imm_fmt.sv
// Combinational RISC-V immediate decoder: classifies the instruction format from
// the opcode and produces the immediate sign-extended to DATA_WIDTH.
module rv_imm_fmt
  import rv_imm_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]           instr_i,
  output logic [2:0]            fmt_o,
  output logic [DATA_WIDTH-1:0] imm_o
);

  logic signed [31:0] imm32;

  always_comb begin
    fmt_o = IMM_FMT_NONE;
    imm32 = '0;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM: begin
        fmt_o = IMM_FMT_I;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_STORE: begin
        fmt_o = IMM_FMT_S;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt_o = IMM_FMT_B;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = IMM_FMT_U;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_o = IMM_FMT_J;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      default: begin
        fmt_o = IMM_FMT_NONE;
        imm32 = '0;
      end
    endcase
    // Signed size cast replicates bit 31 up to DATA_WIDTH.
    imm_o = DATA_WIDTH'(imm32);
  end

endmodule

// File: rtl/rv_imm_arb.sv
// Round-robin arbiter sharing one immediate decoder between NUM_REQ requesters,
// with a single registered valid/ready response stage. Optional perf counters
// are enabled by defining RV_IMM_ARB_PERF_EN.
module rv_imm_arb
  import rv_imm_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_REQ    = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [32*NUM_REQ-1:0]   req_instr_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_imm_o,
  output logic [2:0]              rsp_fmt_o,
  output logic [ID_W-1:0]         rsp_id_o
`ifdef RV_IMM_ARB_PERF_EN
  ,
  output logic [32*NUM_REQ-1:0]   perf_grant_cnt_o,
  output logic [31:0]             perf_stall_cnt_o
`endif
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [0:0]            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [2:0]            fmt_q, fmt_d;
  logic [ID_W-1:0]       id_q, id_d;

  logic                  can_accept;
  logic                  found;
  logic [ID_W-1:0]       winner;
  logic [ID_W:0]         cand;
  logic [ID_W:0]         ptr_inc;
  logic [31:0]           sel_instr;
  logic                  transfer;
  logic [2:0]            dec_fmt;
  logic [DATA_WIDTH-1:0] dec_imm;

  assign rsp_valid_o = (state_q == ST_FULL);
  assign can_accept  = !rsp_valid_o || rsp_ready_i;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req_valid_i[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_instr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == winner) sel_instr = req_instr_i[32*k +: 32];
    end
  end

  assign transfer    = rst_ni && can_accept && found;
  assign req_ready_o = transfer ? (NUM_REQ'(1) << winner) : '0;

  rv_imm_fmt #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fmt (
    .instr_i (sel_instr),
    .fmt_o   (dec_fmt),
    .imm_o   (dec_imm)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    imm_d   = imm_q;
    fmt_d   = fmt_q;
    id_d    = id_q;
    ptr_inc = {1'b0, winner} + 1'b1;
    if (ptr_inc == NUM_REQ_W) ptr_inc = '0;
    if (transfer) begin
      state_d = ST_FULL;
      ptr_d   = ptr_inc[ID_W-1:0];
      imm_d   = dec_imm;
      fmt_d   = dec_fmt;
      id_d    = winner;
    end else if (rsp_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      imm_q   <= '0;
      fmt_q   <= IMM_FMT_NONE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      imm_q   <= imm_d;
      fmt_q   <= fmt_d;
      id_q    <= id_d;
    end
  end

  assign rsp_imm_o = imm_q;
  assign rsp_fmt_o = fmt_q;
  assign rsp_id_o  = id_q;

`ifdef RV_IMM_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]              stall_cnt_q, stall_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k] && req_ready_o[k]) grant_cnt_d[k] = grant_cnt_q[k] + 32'd1;
    end
    if (rsp_valid_o && !rsp_ready_i) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_grant_cnt_o = grant_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
